// File: rtl/bufmem_arbiter.sv
// Arbitrates a single-port buffer RAM between host strobes (always win) and a stream requester.
// Optional stream stall statistics are enabled with `define BUFARB_STATS_EN.
module bufmem_arbiter #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_rd,
    input  logic                  host_wr,
    input  logic                  host_idx_wr,
    input  logic [WIDTH-1:0]      host_wdata,
    output logic [WIDTH-1:0]      host_rdata,
    output logic                  host_rvalid,
    output logic                  host_err,
    output logic [DEPTH_LOG2-1:0] index,
    input  logic                  strm_req,
    input  logic                  strm_we,
    input  logic [DEPTH_LOG2-1:0] strm_addr,
    input  logic [WIDTH-1:0]      strm_wdata,
    output logic                  strm_gnt,
    output logic [WIDTH-1:0]      strm_rdata,
    output logic                  strm_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_HOST_RD = 2'd1,
        TAG_STRM_RD = 2'd2,
        TAG_WR      = 2'd3
    } tag_t;

    tag_t                  tag1_q, tag2_q;
    tag_t                  tag1_d, tag2_d;
    logic                  en_d, we_d;
    logic [DEPTH_LOG2-1:0] addr_d, index_d;
    logic [WIDTH-1:0]      wdata_d;
    logic [WIDTH-1:0]      host_hold_q, strm_hold_q;
    logic                  host_any, host_multi;

    assign host_any   = host_rd | host_wr | host_idx_wr;
    assign host_multi = (host_wr & host_rd) | (host_wr & host_idx_wr) | (host_rd & host_idx_wr);
    assign strm_gnt   = strm_req & ~host_any;

    always_comb begin
        tag1_d  = TAG_NONE;
        tag2_d  = tag1_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        index_d = index;
        if (host_wr) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = index;
            wdata_d = host_wdata;
            tag1_d  = TAG_WR;
            index_d = index + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
        end else if (host_rd) begin
            en_d    = 1'b1;
            addr_d  = index;
            tag1_d  = TAG_HOST_RD;
            index_d = index + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
        end else if (host_idx_wr) begin
            index_d = host_wdata[DEPTH_LOG2-1:0];
        end else if (strm_gnt) begin
            en_d    = 1'b1;
            we_d    = strm_we;
            addr_d  = strm_addr;
            wdata_d = strm_wdata;
            tag1_d  = strm_we ? TAG_WR : TAG_STRM_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            index       <= '0;
            host_err    <= 1'b0;
            host_hold_q <= '0;
            strm_hold_q <= '0;
        end else begin
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            ram_en    <= en_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            index     <= index_d;
            host_err  <= host_multi;
            if (tag2_q == TAG_HOST_RD) host_hold_q <= ram_rdata;
            if (tag2_q == TAG_STRM_RD) strm_hold_q <= ram_rdata;
        end
    end

    // RAM data is forwarded during the valid cycle so read latency stays at two;
    // the hold registers keep it stable until the next read of that owner.
    assign host_rvalid = (tag2_q == TAG_HOST_RD);
    assign strm_rvalid = (tag2_q == TAG_STRM_RD);
    assign host_rdata  = host_rvalid ? ram_rdata : host_hold_q;
    assign strm_rdata  = strm_rvalid ? ram_rdata : strm_hold_q;

`ifdef BUFARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset || host_idx_wr) begin
            stall_q <= 16'h0000;
        end else if (strm_req && !strm_gnt && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Directed bench for bufmem_arbiter with a behavioural synchronous RAM model.
// Stall-counter expectations follow BUFARB_STATS_EN.
module tb_bufmem_arbiter;
    localparam int DL = 9;
    localparam int W  = 16;

`ifdef BUFARB_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          host_rd, host_wr, host_idx_wr;
    logic [W-1:0]  host_wdata, host_rdata;
    logic          host_rvalid, host_err;
    logic [DL-1:0] index;
    logic          strm_req, strm_we;
    logic [DL-1:0] strm_addr;
    logic [W-1:0]  strm_wdata;
    logic          strm_gnt;
    logic [W-1:0]  strm_rdata;
    logic          strm_rvalid;
    logic          ram_en, ram_we;
    logic [DL-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata = '0;
    logic [15:0]   stall_cnt;

    logic [W-1:0]  mem [0:(1<<DL)-1];

    int compared   = 0;
    int mismatched = 0;

    bufmem_arbiter #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .host_rd(host_rd), .host_wr(host_wr), .host_idx_wr(host_idx_wr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_err(host_err), .index(index),
        .strm_req(strm_req), .strm_we(strm_we), .strm_addr(strm_addr),
        .strm_wdata(strm_wdata), .strm_gnt(strm_gnt), .strm_rdata(strm_rdata),
        .strm_rvalid(strm_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic req, rd, wr, idx;
        logic exp_gnt;
    } gnt_vec_t;

    task tick();
        @(posedge clk);
        #1;
    endtask

    task clear_inputs();
        host_rd     = 1'b0;
        host_wr     = 1'b0;
        host_idx_wr = 1'b0;
        host_wdata  = '0;
        strm_req    = 1'b0;
        strm_we     = 1'b0;
        strm_addr   = '0;
        strm_wdata  = '0;
    endtask

    task check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task set_index(input logic [DL-1:0] v);
        host_idx_wr = 1'b1;
        host_wdata  = W'(v);
        tick();
        host_idx_wr = 1'b0;
    endtask

    initial begin
        gnt_vec_t    gvec [8];
        logic [15:0] vals [3];
        logic [DL-1:0] waddr [3];
        logic        exp_v [12];
        logic [15:0] exp_d [12];

        gvec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gvec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        gvec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        gvec[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        gvec[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        gvec[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        gvec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        gvec[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vals[0] = 16'hAAAA; vals[1] = 16'hBBBB; vals[2] = 16'hCCCC;
        waddr[0] = 9'h1FE;  waddr[1] = 9'h1FF;  waddr[2] = 9'h000;

        reset = 1'b1;
        clear_inputs();
        tick();
        tick();

        // Grant is combinational, so the table is applied while reset holds state still.
        for (int i = 0; i < 8; i++) begin
            strm_req = gvec[i].req; host_rd = gvec[i].rd;
            host_wr = gvec[i].wr; host_idx_wr = gvec[i].idx;
            #1;
            check_output($sformatf("gnt_vec%0d", i), 32'(strm_gnt), 32'(gvec[i].exp_gnt));
        end
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
        check_output("rst_index", 32'(index), 0);
        check_output("rst_host_rdata", 32'(host_rdata), 0);
        check_output("rst_strm_rdata", 32'(strm_rdata), 0);
        check_output("rst_host_rvalid", 32'(host_rvalid), 0);
        check_output("rst_strm_rvalid", 32'(strm_rvalid), 0);
        check_output("rst_host_err", 32'(host_err), 0);
        check_output("rst_ram_en", 32'(ram_en), 0);
        check_output("rst_ram_we", 32'(ram_we), 0);
        check_output("rst_ram_addr", 32'(ram_addr), 0);
        check_output("rst_ram_wdata", 32'(ram_wdata), 0);
        check_output("rst_stall_cnt", 32'(stall_cnt), 0);

        // Host writes wrapping the index from 0x1FE through 0x000.
        set_index(9'h1FE);
        check_output("idx_load", 32'(index), 32'h1FE);
        for (int i = 0; i < 3; i++) begin
            host_wr = 1'b1;
            host_wdata = vals[i];
            tick();
            host_wr = 1'b0;
            check_output($sformatf("wr%0d_en", i), 32'(ram_en), 1);
            check_output($sformatf("wr%0d_we", i), 32'(ram_we), 1);
            check_output($sformatf("wr%0d_addr", i), 32'(ram_addr), 32'(waddr[i]));
            check_output($sformatf("wr%0d_wdata", i), 32'(ram_wdata), 32'(vals[i]));
        end
        check_output("wr_index_wrap", 32'(index), 32'h001);
        tick();
        check_output("mem_000", 32'(mem[0]), 32'hCCCC);

        // Host reads back, latency two, data held afterwards.
        set_index(9'h1FE);
        for (int c = 0; c < 6; c++) begin
            host_rd = (c < 3);
            #1;
            check_output($sformatf("rd_rvalid_c%0d", c), 32'(host_rvalid), 32'(c >= 2 && c < 5));
            if (c >= 2 && c < 5)
                check_output($sformatf("rd_rdata_c%0d", c), 32'(host_rdata), 32'(vals[c-2]));
            tick();
        end
        host_rd = 1'b0;
        check_output("rd_hold", 32'(host_rdata), 32'hCCCC);
        check_output("rd_hold_rvalid", 32'(host_rvalid), 0);
        check_output("rd_index", 32'(index), 32'h001);

        // Stream reads of 0..7 with a host write stealing cycle 3.
        set_index(9'h000);
        for (int i = 0; i < 8; i++) begin
            host_wr = 1'b1;
            host_wdata = 16'h5000 + 16'(i);
            tick();
        end
        host_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
        for (int c = 0; c < 10; c++) begin
            strm_req = (c < 8);
            strm_we = 1'b0;
            strm_addr = DL'(c);
            host_wr = (c == 3);
            host_wdata = 16'h1234;
            if (c < 8 && c != 3) begin
                exp_v[c+2] = 1'b1;
                exp_d[c+2] = 16'h5000 + 16'(c);
            end
            #1;
            check_output($sformatf("strm_gnt_c%0d", c), 32'(strm_gnt), 32'(c < 8 && c != 3));
            check_output($sformatf("strm_rvalid_c%0d", c), 32'(strm_rvalid), 32'(exp_v[c]));
            if (exp_v[c])
                check_output($sformatf("strm_rdata_c%0d", c), 32'(strm_rdata), 32'(exp_d[c]));
            check_output($sformatf("strm_host_rvalid_c%0d", c), 32'(host_rvalid), 0);
            tick();
        end
        clear_inputs();
        check_output("strm_index", 32'(index), 32'h009);
        set_index(9'h008);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        tick();
        check_output("strm_hostwr_rvalid", 32'(host_rvalid), 1);
        check_output("strm_hostwr_landed", 32'(host_rdata), 32'h1234);

        // Simultaneous strobes: write beats read, read beats index load.
        set_index(9'h010);
        host_wr = 1'b1; host_rd = 1'b1; host_wdata = 16'hDEAD;
        tick();
        clear_inputs();
        check_output("err_wr_rd_pulse", 32'(host_err), 1);
        check_output("err_wr_rd_we", 32'(ram_we), 1);
        check_output("err_wr_rd_addr", 32'(ram_addr), 32'h010);
        check_output("err_wr_rd_index", 32'(index), 32'h011);
        tick();
        check_output("err_wr_rd_clear", 32'(host_err), 0);
        check_output("err_wr_rd_no_rvalid_t2", 32'(host_rvalid), 0);
        tick();
        check_output("err_wr_rd_no_rvalid_t3", 32'(host_rvalid), 0);
        check_output("err_wr_rd_mem", 32'(mem[16]), 32'hDEAD);
        host_rd = 1'b1; host_idx_wr = 1'b1; host_wdata = 16'h0055;
        tick();
        clear_inputs();
        check_output("err_rd_idx_pulse", 32'(host_err), 1);
        check_output("err_rd_idx_index", 32'(index), 32'h012);
        check_output("err_rd_idx_addr", 32'(ram_addr), 32'h011);
        check_output("err_rd_idx_we", 32'(ram_we), 0);
        tick();
        check_output("err_rd_idx_rvalid", 32'(host_rvalid), 1);

        // Reset the cycle after a stream read grant.
        strm_req = 1'b1; strm_we = 1'b0; strm_addr = 9'h005;
        #1;
        check_output("mid_rst_gnt", 32'(strm_gnt), 1);
        tick();
        strm_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("mid_rst_strm_rvalid", 32'(strm_rvalid), 0);
        check_output("mid_rst_index", 32'(index), 0);
        check_output("mid_rst_ram_en", 32'(ram_en), 0);
        check_output("mid_rst_ram_addr", 32'(ram_addr), 0);
        check_output("mid_rst_ram_wdata", 32'(ram_wdata), 0);
        check_output("mid_rst_host_rdata", 32'(host_rdata), 0);
        check_output("mid_rst_strm_rdata", 32'(strm_rdata), 0);
        check_output("mid_rst_host_err", 32'(host_err), 0);
        check_output("mid_rst_stall", 32'(stall_cnt), 0);
        tick();
        check_output("mid_rst_strm_rvalid_late", 32'(strm_rvalid), 0);

        // Stall counting under a continuous stream request.
        for (int c = 0; c < 5; c++) begin
            strm_req = 1'b1;
            strm_addr = 9'h000;
            host_wr = (c == 0 || c == 3);
            host_rd = (c == 2);
            host_wdata = 16'h0F0F;
            tick();
        end
        host_wr = 1'b0; host_rd = 1'b0;
        check_output("stall_three", 32'(stall_cnt), STATS ? 32'd3 : 32'd0);
        host_idx_wr = 1'b1;
        host_wdata = 16'h0000;
        tick();
        clear_inputs();
        check_output("stall_clear", 32'(stall_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
